ram_param_limpa: RTL and testbench

- Parametrised single-port synchronous RAM; next generation of the team's fixed 8x16 RAM.
- Width and depth are generic.
- Read data is registered and qualified by a valid pulse, replacing the tristate bus.
- Adds a hardware clear engine that sweeps every word to a programmable value, after reset and on demand; datapath blocks use it as scratch/register-file storage.

---
 rtl/ram_param_limpa_pkg.sv | 21 ++
 rtl/ram_param_limpa_if.sv | 32 +++
 rtl/ram_param_limpa_nucleo.sv | 52 +++++
 rtl/ram_param_limpa.sv | 120 ++++++++++++
 tb/tb_ram_param_limpa.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_param_limpa_pkg.sv
// Shared definitions for the parametrised RAM with its clear engine:
// FSM state encoding and the address-width helper.
package ram_param_pkg;

  // OCIOSO serves user accesses; LIMPANDO sweeps VALOR_INI through the array.
  typedef enum logic {
    OCIOSO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_t;

  // Address width for a given depth, never narrower than one bit.
  function automatic int calc_addr_w(input int profundidade);
    int w;
    w = $clog2(profundidade);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_param_limpa_if.sv
// Access bus of the parametrised RAM.
//
// Protocol: the requester raises enable for exactly the cycles it wants an
// access; each enabled cycle is one request (write_enable selects write or
// read) and there is no ready/backpressure while ocupado=0. While ocupado=1
// every request is silently dropped. A read is answered one edge later by a
// single-cycle dado_valido pulse with dados_out holding the word; an
// out-of-range request is answered by a single-cycle erro_addr pulse instead.
interface ram_param_limpa_if #(
  parameter int LARGURA = 16,
  parameter int ADDR_W  = 3
);
  logic               enable;
  logic               write_enable;
  logic [ADDR_W-1:0]  addr;
  logic [LARGURA-1:0] dados_in;
  logic               limpar;
  logic [LARGURA-1:0] dados_out;
  logic               dado_valido;
  logic               erro_addr;
  logic               ocupado;

  modport master (
    output enable, write_enable, addr, dados_in, limpar,
    input  dados_out, dado_valido, erro_addr, ocupado
  );

  modport slave (
    input  enable, write_enable, addr, dados_in, limpar,
    output dados_out, dado_valido, erro_addr, ocupado
  );
endinterface

// File: rtl/ram_param_limpa_nucleo.sv
// Storage core: synchronous array with one write port and one registered
// read port. The read register can also be forced to zero (used for
// out-of-range reads) and is the only state here with a reset.
module ram_nucleo #(
  parameter int LARGURA      = 16,
  parameter int PROFUNDIDADE = 8,
  parameter int ADDR_W       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [LARGURA-1:0] wdata,
  input  logic               re,
  input  logic               rzero,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [LARGURA-1:0] rdata
);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [LARGURA-1:0] rdata_d;
  logic [LARGURA-1:0] rdata_q;

  // Array write; contents are deliberately not reset, the clear sweep does that.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Next read-register value: hold, load a word, or clear on a bad address.
  always_comb begin
    rdata_d = rdata_q;
    if (rzero) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read data register, cleared asynchronously so dados_out is never unknown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_param_limpa.sv
// Parametrised single-port RAM with registered, valid-qualified read data,
// address range checking and a clear engine that writes VALOR_INI to every
// word after reset and whenever limpar is sampled high while idle.
module ram_param_limpa
  import ram_param_pkg::*;
#(
  parameter int                 LARGURA      = 16,
  parameter int                 PROFUNDIDADE = 8,
  parameter logic [LARGURA-1:0] VALOR_INI    = '0
) (
  input  logic                clk,
  input  logic                reset,
  ram_param_limpa_if.slave    bus,
  output estado_t             estado_dbg
);

  localparam int ADDR_W = calc_addr_w(PROFUNDIDADE);
  // Depth widened by one bit so the range compare works for any depth.
  localparam logic [ADDR_W:0]   PROF_EXT = (ADDR_W + 1)'(PROFUNDIDADE);
  localparam logic [ADDR_W-1:0] ULTIMO   = ADDR_W'(PROFUNDIDADE - 1);

  estado_t             estado_d, estado_q;
  logic [ADDR_W-1:0]   ponteiro_d, ponteiro_q;
  logic                valido_d, valido_q;
  logic                erro_d, erro_q;

  logic                addr_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [LARGURA-1:0]  mem_wdata;
  logic                rd_en;
  logic                rd_zero;

  assign addr_ok = ({1'b0, bus.addr} < PROF_EXT);

  // Next state, sweep pointer, write-port mux and response pulses.
  always_comb begin
    estado_d   = estado_q;
    ponteiro_d = ponteiro_q;
    valido_d   = 1'b0;
    erro_d     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ponteiro_q;
    mem_wdata  = VALOR_INI;
    rd_en      = 1'b0;
    rd_zero    = 1'b0;
    case (estado_q)
      LIMPANDO: begin
        // One word per cycle; user requests and limpar are ignored here.
        mem_we = 1'b1;
        if (ponteiro_q == ULTIMO) begin
          estado_d   = OCIOSO;
          ponteiro_d = '0;
        end else begin
          ponteiro_d = ponteiro_q + ADDR_W'(1);
        end
      end
      OCIOSO: begin
        if (bus.limpar) begin
          // Clear request wins; any access in this cycle is dropped.
          estado_d   = LIMPANDO;
          ponteiro_d = '0;
        end else if (bus.enable) begin
          if (!addr_ok) begin
            erro_d  = 1'b1;
            rd_zero = !bus.write_enable;
          end else if (bus.write_enable) begin
            mem_we    = 1'b1;
            mem_waddr = bus.addr;
            mem_wdata = bus.dados_in;
          end else begin
            rd_en    = 1'b1;
            valido_d = 1'b1;
          end
        end
      end
      default: begin
        estado_d   = LIMPANDO;
        ponteiro_d = '0;
      end
    endcase
  end

  // Control registers; reset lands in LIMPANDO so the sweep starts at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= LIMPANDO;
      ponteiro_q <= '0;
      valido_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ponteiro_q <= ponteiro_d;
      valido_q   <= valido_d;
      erro_q     <= erro_d;
    end
  end

  ram_nucleo #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE),
    .ADDR_W       (ADDR_W)
  ) u_nucleo (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_en),
    .rzero (rd_zero),
    .raddr (bus.addr),
    .rdata (bus.dados_out)
  );

  assign bus.dado_valido = valido_q;
  assign bus.erro_addr   = erro_q;
  assign bus.ocupado     = (estado_q == LIMPANDO);
  assign estado_dbg      = estado_q;

endmodule

// File: tb/tb_ram_param_limpa.sv
// Bench for ram_param_limpa: one instance with depth 8 (VALOR_INI=A5A5) and
// one with depth 6 (VALOR_INI=5A5A). Drivers push the expected response of
// every request into a per-instance queue; a negedge monitor pops and checks
// whenever an instance pulses dado_valido or erro_addr.
module tb_ram_param_limpa;
  import ram_param_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        en  [2];
  logic        we  [2];
  logic        lim [2];
  logic [2:0]  ad  [2];
  logic [15:0] din [2];

  int checks = 0;
  int errors = 0;

  // Entry: [17] error response, [16] compare data, [15:0] data.
  logic [17:0] exp_q_a[$];
  logic [17:0] exp_q_b[$];

  ram_param_limpa_if #(.LARGURA(16), .ADDR_W(3)) bus_a ();
  ram_param_limpa_if #(.LARGURA(16), .ADDR_W(3)) bus_b ();

  estado_t dbg_a, dbg_b;

  assign bus_a.enable       = en[0];
  assign bus_a.write_enable = we[0];
  assign bus_a.addr         = ad[0];
  assign bus_a.dados_in     = din[0];
  assign bus_a.limpar       = lim[0];
  assign bus_b.enable       = en[1];
  assign bus_b.write_enable = we[1];
  assign bus_b.addr         = ad[1];
  assign bus_b.dados_in     = din[1];
  assign bus_b.limpar       = lim[1];

  ram_param_limpa #(.LARGURA(16), .PROFUNDIDADE(8), .VALOR_INI(16'hA5A5)) dut_a (
    .clk(clk), .reset(rst[0]), .bus(bus_a.slave), .estado_dbg(dbg_a)
  );

  ram_param_limpa #(.LARGURA(16), .PROFUNDIDADE(6), .VALOR_INI(16'h5A5A)) dut_b (
    .clk(clk), .reset(rst[1]), .bus(bus_b.slave), .estado_dbg(dbg_b)
  );

  // ---------------- helpers ----------------
  function automatic logic ocup(input int s);
    return (s == 0) ? bus_a.ocupado : bus_b.ocupado;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input int s, input logic [17:0] e);
    if (s == 0) exp_q_a.push_back(e);
    else        exp_q_b.push_back(e);
  endtask

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic do_write(input int s, input logic [2:0] a, input logic [15:0] d, input bit bad);
    if (bad) push_exp(s, {1'b1, 1'b0, 16'h0000});
    en[s] = 1'b1; we[s] = 1'b1; ad[s] = a; din[s] = d;
    @(posedge clk); #1;
    en[s] = 1'b0; we[s] = 1'b0;
  endtask

  task automatic do_read(input int s, input logic [2:0] a, input logic [15:0] expd, input bit bad);
    if (bad) push_exp(s, {1'b1, 1'b1, 16'h0000});
    else     push_exp(s, {1'b0, 1'b1, expd});
    en[s] = 1'b1; we[s] = 1'b0; ad[s] = a;
    @(posedge clk); #1;
    en[s] = 1'b0;
  endtask

  // Count negedges with ocupado high, starting at the next negedge.
  task automatic wait_sweep(input int s, input int expected, input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ocup(s)) n++;
      else break;
    end
    check(nm, 16'(n), 16'(expected));
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int s, input logic v, input logic e, input logic [15:0] d);
    logic [17:0] x;
    int          sz;
    if (v || e) begin
      checks++;
      sz = (s == 0) ? exp_q_a.size() : exp_q_b.size();
      if (sz == 0) begin
        errors++;
        $display("FAIL unexpected_pulse dut=%0d valido=%b erro=%b dados=%h required=no_pulse", s, v, e, d);
      end else begin
        x = (s == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
        if (v !== !x[17] || e !== x[17] || (x[16] && d !== x[15:0])) begin
          errors++;
          $display("FAIL response dut=%0d valido=%b erro=%b dados=%h required valido=%b erro=%b dados=%h",
                   s, v, e, d, !x[17], x[17], x[15:0]);
        end
      end
    end
  endtask

  always @(negedge clk) if (rst[0] === 1'b0) mon(0, bus_a.dado_valido, bus_a.erro_addr, bus_a.dados_out);
  always @(negedge clk) if (rst[1] === 1'b0) mon(1, bus_b.dado_valido, bus_b.erro_addr, bus_b.dados_out);

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; en[s] = 1'b0; we[s] = 1'b0; lim[s] = 1'b0;
      ad[s] = '0; din[s] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_a_ocupado", 16'(bus_a.ocupado),     16'd1);
    check("rst_a_dados",   bus_a.dados_out,        16'h0000);
    check("rst_a_valido",  16'(bus_a.dado_valido), 16'd0);
    check("rst_a_erro",    16'(bus_a.erro_addr),   16'd0);
    check("rst_b_ocupado", 16'(bus_b.ocupado),     16'd1);
    check("rst_b_dados",   bus_b.dados_out,        16'h0000);

    // Depth 8: initial sweep length, then every word holds A5A5.
    @(posedge clk); #1;
    rst[0] = 1'b0;
    wait_sweep(0, 8, "a_sweep_after_reset");
    for (int a = 0; a < 8; a++) do_read(0, 3'(a), 16'hA5A5, 1'b0);

    // Write then read next cycle; data holds afterwards with no pulse.
    do_write(0, 3'd3, 16'h1234, 1'b0);
    do_read(0, 3'd3, 16'h1234, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("a_hold_dados",  bus_a.dados_out,        16'h1234);
    check("a_hold_valido", 16'(bus_a.dado_valido), 16'd0);
    @(posedge clk); #1;

    // Alternating write/read, one access per cycle with no gaps.
    for (int a = 0; a < 8; a++) begin
      do_write(0, 3'(a), 16'h0100 + 16'(a), 1'b0);
      do_read(0, 3'(a), 16'h0100 + 16'(a), 1'b0);
    end

    // Reset in the middle of a clear sweep; reads during the sweep are ignored.
    do_write(0, 3'd7, 16'hBEEF, 1'b0);
    lim[0] = 1'b1;
    @(posedge clk); #1;
    lim[0] = 1'b0;
    en[0] = 1'b1; we[0] = 1'b0; ad[0] = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    check("a_midsweep_rst_ocupado", 16'(bus_a.ocupado), 16'd1);
    check("a_midsweep_rst_dados",   bus_a.dados_out,    16'h0000);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    wait_sweep(0, 8, "a_sweep_after_midsweep_reset");
    do_read(0, 3'd7, 16'hA5A5, 1'b0);
    do_read(0, 3'd3, 16'hA5A5, 1'b0);

    // Depth 6: sweep length, range errors, untouched words.
    rst[1] = 1'b0;
    wait_sweep(1, 6, "b_sweep_after_reset");
    for (int a = 0; a < 6; a++) do_write(1, 3'(a), 16'h0600 + 16'(a), 1'b0);
    do_read(1, 3'd6, 16'h0000, 1'b1);
    do_write(1, 3'd7, 16'hDEAD, 1'b1);
    for (int a = 0; a < 6; a++) do_read(1, 3'(a), 16'h0600 + 16'(a), 1'b0);

    // limpar together with a write: the write is dropped, full sweep follows.
    lim[1] = 1'b1; en[1] = 1'b1; we[1] = 1'b1; ad[1] = 3'd2; din[1] = 16'hFFFF;
    @(posedge clk); #1;
    lim[1] = 1'b0; en[1] = 1'b0; we[1] = 1'b0;
    wait_sweep(1, 6, "b_sweep_after_limpar");
    do_read(1, 3'd2, 16'h5A5A, 1'b0);
    do_read(1, 3'd5, 16'h5A5A, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("a_queue_drained", 16'(exp_q_a.size()), 16'd0);
    check("b_queue_drained", 16'(exp_q_b.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
